// File: rtl/simple_axi_pkg.sv
// Shared definitions for the simple_axi host-bus blocks: op and size encodings
// plus the arbiter state type.
package simple_axi_pkg;

  typedef enum logic [1:0] {
    RW_IDLE    = 2'b00,
    RW_WRITE   = 2'b01,
    RW_READ    = 2'b10,
    RW_ILLEGAL = 2'b11
  } rw_op_t;

  typedef enum logic [2:0] {
    SIZE_B = 3'b000,
    SIZE_H = 3'b001,
    SIZE_W = 3'b010,
    SIZE_D = 3'b011
  } axi_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    COMPLETE
  } arb_state_t;

endpackage

// File: rtl/simple_axi_rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr, wrapping
// modulo N_REQ.
module simple_axi_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/simple_axi_arbiter.sv
// Round-robin arbiter sharing one simple_axi_master among N_REQ requesters;
// runs the master's done/clear_done handshake on the granted requester's behalf.
module simple_axi_arbiter
  import simple_axi_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [2*N_REQ-1:0]    i_req_rw,
  input  logic [ADDR_W*N_REQ-1:0] i_req_addr,
  input  logic [3*N_REQ-1:0]    i_req_size,
  input  logic [DATA_W*N_REQ-1:0] i_req_wdata,
  input  logic [N_REQ-1:0]      i_req_clear_done,
  output logic [DATA_W-1:0]     o_req_rdata,
  output logic [N_REQ-1:0]      o_req_wait,
  output logic [N_REQ-1:0]      o_req_done,
  output logic [N_REQ-1:0]      o_req_error,
  output logic [N_REQ-1:0]      o_req_invalid,
  output logic [ADDR_W-1:0]     o_m_addr,
  output logic [2:0]            o_m_size,
  output logic [DATA_W-1:0]     o_m_wdata,
  output logic [1:0]            o_m_rw,
  output logic                  o_m_clear_done,
  input  logic [DATA_W-1:0]     i_m_rdata,
  input  logic                  i_m_wait,
  input  logic                  i_m_done,
  input  logic                  i_m_invalid,
  input  logic                  i_m_error
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state, next_state;
  logic [IDX_W-1:0]  g, rr_ptr, next_ptr;
  logic [N_REQ-1:0]  req_active;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [1:0]        pick_rw;
  logic [DATA_W-1:0] cap_rdata;
  logic              cap_error, cap_invalid;

  // The master's wait line carries no information the done handshake lacks.
  logic unused_m_wait;
  assign unused_m_wait = i_m_wait;

  always_comb begin
    req_active = '0;
    for (int i = 0; i < N_REQ; i++)
      req_active[i] = (i_req_rw[2*i +: 2] != RW_IDLE);
  end

  simple_axi_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_active),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_rw  = i_req_rw[int'(pick_idx)*2 +: 2];
  assign next_ptr = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (pick_found)
                  next_state = (pick_rw == RW_ILLEGAL) ? COMPLETE : BUSY;
      BUSY:     if (i_m_done) next_state = ACK;
      ACK:      next_state = COMPLETE;
      COMPLETE: if (i_req_clear_done[g]) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      g              <= '0;
      rr_ptr         <= '0;
      o_m_addr       <= '0;
      o_m_size       <= '0;
      o_m_wdata      <= '0;
      o_m_rw         <= RW_IDLE;
      o_m_clear_done <= 1'b0;
      cap_rdata      <= '0;
      cap_error      <= 1'b0;
      cap_invalid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          g      <= pick_idx;
          rr_ptr <= next_ptr;
          if (pick_rw == RW_ILLEGAL) begin
            // Rejected locally: the master never sees this request.
            cap_error   <= 1'b0;
            cap_invalid <= 1'b1;
          end else begin
            o_m_addr  <= i_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            o_m_size  <= i_req_size[int'(pick_idx)*3 +: 3];
            o_m_wdata <= i_req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            o_m_rw    <= pick_rw;
          end
        end
        BUSY: if (i_m_done) begin
          cap_rdata      <= i_m_rdata;
          cap_error      <= i_m_error;
          cap_invalid    <= i_m_invalid;
          o_m_rw         <= RW_IDLE;
          o_m_clear_done <= 1'b1;
        end
        ACK:     o_m_clear_done <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_req_done    = '0;
    o_req_error   = '0;
    o_req_invalid = '0;
    if (state == COMPLETE) begin
      o_req_done[g]    = 1'b1;
      o_req_error[g]   = cap_error;
      o_req_invalid[g] = cap_invalid;
    end
  end

  assign o_req_wait  = req_active & ~o_req_done;
  assign o_req_rdata = cap_rdata;

endmodule
